bus_hold_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 36 +++
 rtl/bus_priority_encoder.sv | 28 ++
 rtl/bus_hold_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bus_hold_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the system bus hold arbiter family.
// The wrap-around search is shared by the bus and interrupt arbiters.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ARB,
        AEN,
        GRANT,
        RELEASE
    } arb_state_t;

    localparam int MAX_MASTERS = 8;

    // Index of the first set bit at or above start, wrapping at num; -1 when none.
    function automatic int wrap_search(
        input logic [MAX_MASTERS-1:0] req,
        input int                     start,
        input int                     num
    );
        int sel;
        int idx;
        sel = -1;
        for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
            if (k < num) begin
                idx = (start + k) % num;
                if (req[3'(idx)]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_priority_encoder.sv
// Combinational requester selection: fixed (index 0 first) or rotating
// (search upward from start, wrapping).
module bus_priority_encoder
    import bus_arbiter_pkg::*;
#(
    parameter int  NUM_MASTERS = 4,
    parameter int  ROTATING    = 1,
    localparam int OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [OWNER_W-1:0]     start,
    output logic                   found,
    output logic [OWNER_W-1:0]     index
);

    logic [MAX_MASTERS-1:0] req_ext;
    int                     sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_ext                    = '0;
        req_ext[NUM_MASTERS-1:0]   = request;
        sel   = wrap_search(req_ext, (ROTATING != 0) ? int'(start) : 0, NUM_MASTERS);
        found = (sel >= 0);
        index = OWNER_W'(sel);
    end

endmodule

// File: rtl/bus_hold_arbiter.sv
// N-master hold arbiter for the 8088 system bus; hold handshakes are paced
// by cpu_clock edges sampled in the clock domain.
module bus_hold_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int  NUM_MASTERS       = 4,
    parameter int  ROTATING_PRIORITY = 1,
    parameter int  MAX_BURST         = 0,
    localparam int OWNER_W           = $clog2(NUM_MASTERS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cpu_clock,
    input  logic [2:0]             processor_status,
    input  logic                   processor_lock_n,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   owner_valid,
    output logic [OWNER_W-1:0]     owner_index,
    output logic                   address_enable_n,
    output logic                   dma_wait_n,
    output logic                   release_pulse
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_t             state, state_d;
    logic                   prev_cpu_clock;
    logic [OWNER_W-1:0]     winner, winner_d;
    logic [OWNER_W-1:0]     rr_pointer, rr_pointer_d;
    logic [BURST_W-1:0]     burst_count, burst_count_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic                   owner_valid_d;
    logic [OWNER_W-1:0]     owner_index_d;
    logic                   address_enable_n_d;
    logic                   dma_wait_n_d;
    logic                   release_pulse_d;

    logic                   cpu_pos, cpu_neg;
    logic                   pe_found;
    logic [OWNER_W-1:0]     pe_index;
    logic [NUM_MASTERS-1:0] winner_mask;
    logic                   winner_req, others_req, burst_expired, go_release;
    logic                   unused_ok;

    // Only S1/S0 decide passive T4; S2 is carried for the full status bus.
    assign unused_ok = processor_status[2];

    assign cpu_pos = cpu_clock & ~prev_cpu_clock;
    assign cpu_neg = ~cpu_clock & prev_cpu_clock;

    assign winner_mask   = NUM_MASTERS'(1) << winner;
    assign winner_req    = |(request & winner_mask);
    assign others_req    = |(request & ~winner_mask);
    assign burst_expired = (MAX_BURST != 0) && (int'(burst_count) == MAX_BURST - 1) && others_req;

    bus_priority_encoder #(
        .NUM_MASTERS (NUM_MASTERS),
        .ROTATING    (ROTATING_PRIORITY)
    ) u_priority (
        .request (request),
        .start   (rr_pointer),
        .found   (pe_found),
        .index   (pe_index)
    );

    always_comb begin
        state_d            = state;
        winner_d           = winner;
        rr_pointer_d       = rr_pointer;
        burst_count_d      = burst_count;
        grant_d            = grant;
        owner_valid_d      = owner_valid;
        owner_index_d      = owner_index;
        address_enable_n_d = address_enable_n;
        dma_wait_n_d       = dma_wait_n;
        release_pulse_d    = 1'b0;
        go_release         = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_pos && processor_status[1:0] == 2'b11 && processor_lock_n && |request) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (cpu_neg) begin
                    if (pe_found) begin
                        state_d  = ARB;
                        winner_d = pe_index;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ARB: begin
                // CPU drivers are released even if the winner withdraws here.
                if (cpu_pos) begin
                    address_enable_n_d = 1'b1;
                    if (winner_req) begin
                        state_d = AEN;
                    end else begin
                        go_release = 1'b1;
                    end
                end
            end
            AEN: begin
                if (cpu_pos) begin
                    if (winner_req) begin
                        state_d       = GRANT;
                        grant_d       = winner_mask;
                        owner_valid_d = 1'b1;
                        owner_index_d = winner;
                        dma_wait_n_d  = 1'b0;
                        burst_count_d = '0;
                    end else begin
                        go_release = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (cpu_pos) begin
                    if (!winner_req || burst_expired) begin
                        go_release = 1'b1;
                    end else if (burst_count != '1) begin
                        burst_count_d = burst_count + BURST_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (cpu_pos) begin
                    state_d            = IDLE;
                    address_enable_n_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_release) begin
            state_d         = RELEASE;
            grant_d         = '0;
            owner_valid_d   = 1'b0;
            dma_wait_n_d    = 1'b1;
            release_pulse_d = 1'b1;
            rr_pointer_d    = OWNER_W'((int'(winner) + 1) % NUM_MASTERS);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            prev_cpu_clock   <= 1'b0;
            winner           <= '0;
            rr_pointer       <= '0;
            burst_count      <= '0;
            grant            <= '0;
            owner_valid      <= 1'b0;
            owner_index      <= '0;
            address_enable_n <= 1'b0;
            dma_wait_n       <= 1'b1;
            release_pulse    <= 1'b0;
        end else begin
            state            <= state_d;
            prev_cpu_clock   <= cpu_clock;
            winner           <= winner_d;
            rr_pointer       <= rr_pointer_d;
            burst_count      <= burst_count_d;
            grant            <= grant_d;
            owner_valid      <= owner_valid_d;
            owner_index      <= owner_index_d;
            address_enable_n <= address_enable_n_d;
            dma_wait_n       <= dma_wait_n_d;
            release_pulse    <= release_pulse_d;
        end
    end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter: unlimited rotating, burst-limited
// rotating and burst-limited fixed instances on shared stimulus.
module tb_bus_hold_arbiter;

    localparam logic [2:0] ST_PASSIVE = 3'b111;
    localparam logic [2:0] ST_BUSY    = 3'b100;

    logic       clock;
    logic       reset_n;
    logic       cpu_clock;
    logic [2:0] processor_status;
    logic       processor_lock_n;
    logic [3:0] request;

    logic [3:0] grant, rr_grant, fx_grant;
    logic       owner_valid, rr_ov, fx_ov;
    logic [1:0] owner_index, rr_oi, fx_oi;
    logic       aen_n, rr_aen_n, fx_aen_n;
    logic       dw_n, rr_dw_n, fx_dw_n;
    logic       rp, rr_rp, fx_rp;

    int checks = 0;
    int errors = 0;

    bus_hold_arbiter #(.NUM_MASTERS(4), .ROTATING_PRIORITY(1), .MAX_BURST(0)) dut (
        .clock(clock), .reset_n(reset_n), .cpu_clock(cpu_clock),
        .processor_status(processor_status), .processor_lock_n(processor_lock_n),
        .request(request), .grant(grant), .owner_valid(owner_valid),
        .owner_index(owner_index), .address_enable_n(aen_n),
        .dma_wait_n(dw_n), .release_pulse(rp)
    );

    bus_hold_arbiter #(.NUM_MASTERS(4), .ROTATING_PRIORITY(1), .MAX_BURST(3)) dut_rr (
        .clock(clock), .reset_n(reset_n), .cpu_clock(cpu_clock),
        .processor_status(processor_status), .processor_lock_n(processor_lock_n),
        .request(request), .grant(rr_grant), .owner_valid(rr_ov),
        .owner_index(rr_oi), .address_enable_n(rr_aen_n),
        .dma_wait_n(rr_dw_n), .release_pulse(rr_rp)
    );

    bus_hold_arbiter #(.NUM_MASTERS(4), .ROTATING_PRIORITY(0), .MAX_BURST(3)) dut_fx (
        .clock(clock), .reset_n(reset_n), .cpu_clock(cpu_clock),
        .processor_status(processor_status), .processor_lock_n(processor_lock_n),
        .request(request), .grant(fx_grant), .owner_valid(fx_ov),
        .owner_index(fx_oi), .address_enable_n(fx_aen_n),
        .dma_wait_n(fx_dw_n), .release_pulse(fx_rp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       cpu;
        logic [2:0] status;
        logic       lock_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic       aen_n;
        logic       dw_n;
        logic       ov;
        logic [1:0] oi;
        logic       rp;
    } vec_t;

    vec_t vecs[$];

    int         rr_own[8];
    int         fx_own[8];
    int         rr_cnt, fx_cnt, rr_len, fx_len;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic add(input logic c, input logic [2:0] st, input logic lk, input logic [3:0] rq,
                       input logic [3:0] g, input logic a, input logic d, input logic ov,
                       input logic [1:0] oi, input logic r);
        vec_t v;
        v.cpu = c; v.status = st; v.lock_n = lk; v.req = rq;
        v.grant = g; v.aen_n = a; v.dw_n = d; v.ov = ov; v.oi = oi; v.rp = r;
        vecs.push_back(v);
    endtask

    // One cpu_clock half-phase: drive at a clock negedge, let one posedge see it, sample at the next negedge.
    task automatic step(input logic lvl);
        cpu_clock = lvl;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n          = 1'b0;
        cpu_clock        = 1'b0;
        request          = 4'b0000;
        processor_lock_n = 1'b1;
        processor_status = ST_PASSIVE;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " grant"}, 32'(grant), 32'h0);
        check({tag, " owner_valid"}, 32'(owner_valid), 32'h0);
        check({tag, " owner_index"}, 32'(owner_index), 32'h0);
        check({tag, " aen_n"}, 32'(aen_n), 32'h0);
        check({tag, " dma_wait_n"}, 32'(dw_n), 32'h1);
        check({tag, " release_pulse"}, 32'(rp), 32'h0);
    endtask

    // Runs alternating half-phases starting high, recording each new owner of the burst-limited instances.
    task automatic run_burst(input logic [3:0] req, input int n_steps);
        logic rr_prev, fx_prev;
        for (int i = 0; i < 8; i++) begin
            rr_own[i] = 15;
            fx_own[i] = 15;
        end
        rr_cnt = 0; fx_cnt = 0; rr_len = 0; fx_len = 0;
        rr_prev = 1'b0; fx_prev = 1'b0;
        request = req;
        for (int s = 0; s < n_steps; s++) begin
            step(s % 2 == 0);
            if (rr_ov && !rr_prev && rr_cnt < 8) begin
                rr_own[rr_cnt] = int'(rr_oi);
                rr_cnt++;
            end
            if (fx_ov && !fx_prev && fx_cnt < 8) begin
                fx_own[fx_cnt] = int'(fx_oi);
                fx_cnt++;
            end
            if (rr_grant != 4'b0 && rr_cnt == 1) rr_len++;
            if (fx_grant != 4'b0 && fx_cnt == 1) fx_len++;
            rr_prev = rr_ov;
            fx_prev = fx_ov;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   cpu status      lk req      grant    aen dw ov oi rp
        add(1, ST_PASSIVE, 1, 4'b0100, 4'b0000, 0, 1, 0, 0, 0);
        add(0, ST_PASSIVE, 1, 4'b0100, 4'b0000, 0, 1, 0, 0, 0);
        add(1, ST_PASSIVE, 1, 4'b0100, 4'b0000, 1, 1, 0, 0, 0);
        add(0, ST_PASSIVE, 1, 4'b0100, 4'b0000, 1, 1, 0, 0, 0);
        add(1, ST_PASSIVE, 1, 4'b0100, 4'b0100, 1, 0, 1, 2, 0);
        add(0, ST_PASSIVE, 1, 4'b0000, 4'b0100, 1, 0, 1, 2, 0);
        add(1, ST_PASSIVE, 1, 4'b0000, 4'b0000, 1, 1, 0, 2, 1);
        add(0, ST_PASSIVE, 1, 4'b0000, 4'b0000, 1, 1, 0, 2, 0);
        add(1, ST_PASSIVE, 1, 4'b0000, 4'b0000, 0, 1, 0, 2, 0);
        // Pointer now 3: request 1010 must go to master 3, not 1.
        add(0, ST_PASSIVE, 1, 4'b1010, 4'b0000, 0, 1, 0, 2, 0);
        add(1, ST_PASSIVE, 1, 4'b1010, 4'b0000, 0, 1, 0, 2, 0);
        add(0, ST_PASSIVE, 1, 4'b1010, 4'b0000, 0, 1, 0, 2, 0);
        add(1, ST_PASSIVE, 1, 4'b1010, 4'b0000, 1, 1, 0, 2, 0);
        add(0, ST_PASSIVE, 1, 4'b1010, 4'b0000, 1, 1, 0, 2, 0);
        add(1, ST_PASSIVE, 1, 4'b1010, 4'b1000, 1, 0, 1, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b1010, 4'b1000, 1, 0, 1, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b1010, 4'b1000, 1, 0, 1, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b0010, 4'b1000, 1, 0, 1, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0010, 4'b0000, 1, 1, 0, 3, 1);
        add(0, ST_PASSIVE, 1, 4'b0010, 4'b0000, 1, 1, 0, 3, 0);
        // Waiting master 1 gets no back-to-back handoff.
        add(1, ST_PASSIVE, 1, 4'b0010, 4'b0000, 0, 1, 0, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b0010, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0010, 4'b0000, 0, 1, 0, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b0010, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0010, 4'b0000, 1, 1, 0, 3, 0);
        // Winner withdraws during AEN: release without grant.
        add(0, ST_PASSIVE, 1, 4'b0000, 4'b0000, 1, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0000, 4'b0000, 1, 1, 0, 3, 1);
        add(0, ST_PASSIVE, 1, 4'b0000, 4'b0000, 1, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0000, 4'b0000, 0, 1, 0, 3, 0);
        // LOCK and non-passive status block the hold.
        add(0, ST_PASSIVE, 0, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 0, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(0, ST_PASSIVE, 0, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 0, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(0, ST_BUSY,    1, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_BUSY,    1, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b0001, 4'b0000, 0, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0001, 4'b0000, 1, 1, 0, 3, 0);
        add(0, ST_PASSIVE, 1, 4'b0001, 4'b0000, 1, 1, 0, 3, 0);
        add(1, ST_PASSIVE, 1, 4'b0001, 4'b0001, 1, 0, 1, 0, 0);
        // LOCK during ownership does not preempt.
        add(0, ST_PASSIVE, 0, 4'b0001, 4'b0001, 1, 0, 1, 0, 0);
        add(1, ST_PASSIVE, 0, 4'b0001, 4'b0001, 1, 0, 1, 0, 0);

        reset_n          = 1'b0;
        cpu_clock        = 1'b0;
        request          = 4'b0000;
        processor_lock_n = 1'b1;
        processor_status = ST_PASSIVE;
        do_reset();
        check_idle("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            processor_status = vecs[i].status;
            processor_lock_n = vecs[i].lock_n;
            request          = vecs[i].req;
            step(vecs[i].cpu);
            check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d aen_n", i), 32'(aen_n), 32'(vecs[i].aen_n));
            check($sformatf("vec%0d dma_wait_n", i), 32'(dw_n), 32'(vecs[i].dw_n));
            check($sformatf("vec%0d owner_valid", i), 32'(owner_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d owner_index", i), 32'(owner_index), 32'(vecs[i].oi));
            check($sformatf("vec%0d release_pulse", i), 32'(rp), 32'(vecs[i].rp));
        end

        // Asynchronous reset mid-GRANT, away from any clock edge.
        #2 reset_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clock);
        cpu_clock        = 1'b0;
        processor_lock_n = 1'b1;
        request          = 4'b0001;
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check("post_reset aen_n", 32'(aen_n), 32'h1);
        check("post_reset early grant", 32'(grant), 32'h0);
        step(1'b0);
        step(1'b1);
        check("post_reset grant", 32'(grant), 32'h1);
        check("post_reset dma_wait_n", 32'(dw_n), 32'h0);
        check("post_reset owner_index", 32'(owner_index), 32'h0);

        // All four requesting with a 3-posedge burst limit.
        do_reset();
        run_burst(4'b1111, 60);
        check("rr4 owner count >= 4", 32'(rr_cnt >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr4 owner%0d", i), 32'(rr_own[i]), 32'(i));
            check($sformatf("fx4 owner%0d", i), 32'(fx_own[i]), 32'h0);
        end
        check("rr4 first burst half-phases", 32'(rr_len), 32'd6);
        check("fx4 first burst half-phases", 32'(fx_len), 32'd6);

        do_reset();
        run_burst(4'b0011, 40);
        check("rr2 owner0", 32'(rr_own[0]), 32'h0);
        check("rr2 owner1", 32'(rr_own[1]), 32'h1);
        check("rr2 first burst half-phases", 32'(rr_len), 32'd6);

        // Lone requester keeps the bus past the burst limit.
        do_reset();
        run_burst(4'b0001, 40);
        check("rr1 owner count", 32'(rr_cnt), 32'h1);
        check("rr1 held half-phases", 32'(rr_len), 32'd36);
        check("rr1 final grant", 32'(rr_grant), 32'h1);
        check("rr1 final aen_n", 32'(rr_aen_n), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
